// File: rtl/arb_pkg.sv
// Shared types and constants for the two-channel arbiter request generator.
package arb_pkg;

    localparam int unsigned NUM_CH = 2;

    localparam logic [1:0] GNT_NONE    = 2'b00;
    localparam logic [1:0] GNT_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } chan_state_t;

endpackage

// File: rtl/arb_chan_fifo.sv
// Per-channel synchronous FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle.
module arb_chan_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [DATA_W-1:0]           wdata_i,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [DATA_W-1:0]           head_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              push_ok, pop_ok;

    // Pointer/occupancy next state; full/empty are precomputed into flops.
    always_comb begin
        pop_ok   = pop_i && !empty_q;
        push_ok  = push_i && (!full_q || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/arb_req_gen.sv
// Two-channel buffered request generator in front of a 2-way arbiter.
module arb_req_gen
    import arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_BURST = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          in_ready,
    output logic [NUM_CH-1:0]          request,
    input  logic [NUM_CH-1:0]          grant,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_id,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       grant_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    chan_state_t       state_q [NUM_CH];
    chan_state_t       state_d [NUM_CH];
    logic [BW-1:0]     burst_q [NUM_CH];
    logic [BW-1:0]     burst_d [NUM_CH];
    logic [NUM_CH-1:0] request_q, request_d;
    logic              grant_err_q;

    logic [NUM_CH-1:0] gnt_eff;
    logic [NUM_CH-1:0] fifo_full, fifo_empty;
    logic [NUM_CH-1:0] push_acc, pop, chan_valid, chan_last;
    logic [DATA_W-1:0] fifo_head  [NUM_CH];
    logic [CW-1:0]     fifo_count [NUM_CH];

    // An illegal double grant is treated as no grant for all data movement.
    assign gnt_eff = (grant == GNT_ILLEGAL) ? GNT_NONE : grant;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        arb_chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (push_acc[g]),
            .pop_i   (pop[g]),
            .wdata_i (in_data[g*DATA_W +: DATA_W]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g]),
            .head_o  (fifo_head[g]),
            .count_o (fifo_count[g])
        );
    end

    // Per-channel FSM next state, burst counting and pop/last decode.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            state_d[i]    = state_q[i];
            burst_d[i]    = burst_q[i];
            chan_valid[i] = gnt_eff[i] && (state_q[i] == XFER) && !fifo_empty[i];
            pop[i]        = chan_valid[i] && out_ready;
            push_acc[i]   = in_valid[i] && (!fifo_full[i] || pop[i]);
            chan_last[i]  = chan_valid[i] &&
                            ((burst_q[i] == BW'(MAX_BURST - 1)) ||
                             ((fifo_count[i] == CW'(1)) && !push_acc[i]));
            case (state_q[i])
                IDLE: if (!fifo_empty[i]) state_d[i] = REQ;
                REQ:  if (gnt_eff[i]) state_d[i] = XFER;
                XFER: begin
                    if (!gnt_eff[i]) begin
                        state_d[i] = REQ;
                        burst_d[i] = '0;
                    end else if (fifo_empty[i]) begin
                        state_d[i] = REL;
                        burst_d[i] = '0;
                    end else if (pop[i]) begin
                        if (chan_last[i]) begin
                            state_d[i] = REL;
                            burst_d[i] = '0;
                        end else begin
                            burst_d[i] = burst_q[i] + BW'(1);
                        end
                    end
                end
                REL:     state_d[i] = fifo_empty[i] ? IDLE : REQ;
                default: state_d[i] = IDLE;
            endcase
            request_d[i] = (state_d[i] == REQ) || (state_d[i] == XFER);
        end
    end

    // FSM, burst counter, request and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                burst_q[i] <= '0;
            end
            request_q   <= '0;
            grant_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                burst_q[i] <= burst_d[i];
            end
            request_q   <= request_d;
            grant_err_q <= grant_err_q || (grant == GNT_ILLEGAL);
        end
    end

    // Shared output mux; the effective grant selects at most one channel.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_id    = 1'b0;
        out_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (chan_valid[i]) begin
                out_valid = 1'b1;
                out_data  = fifo_head[i];
                out_id    = 1'(i);
                out_last  = chan_last[i];
            end
        end
    end

    assign in_ready  = ~fifo_full;
    assign request   = request_q;
    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_arb_req_gen.sv
// Scoreboard bench for arb_req_gen: expected output words are queued as
// stimulus is driven and retired by a monitor on accepted output beats.
module tb_arb_req_gen;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ready;
    logic [1:0]  request;
    logic [1:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_id;
    logic        out_last;
    logic        out_ready;
    logic        grant_err;

    int n_cmp = 0;
    int n_err = 0;
    int accepted = 0;
    logic [9:0] exp_q[$];   // {last, id, data}

    arb_req_gen #(.DATA_W(8), .DEPTH(4), .MAX_BURST(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .request   (request),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int ch, input logic [7:0] d);
        in_valid = 2'(1 << ch);
        in_data[ch*8 +: 8] = d;
        tick();
        in_valid = 2'b00;
    endtask

    task automatic expect_word(input logic id, input logic [7:0] d, input logic last);
        exp_q.push_back({last, id, d});
    endtask

    task automatic wait_drained(input string tag, input int max_cycles);
        for (int c = 0; c < max_cycles && exp_q.size() != 0; c++) tick();
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Retire one expected word per accepted output beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_word", {22'b0, out_last, out_id, out_data}, 32'h0);
            end else begin
                check_eq("out_word", {22'b0, out_last, out_id, out_data}, {22'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 2'b00;
        in_data   = '0;
        grant     = 2'b00;
        out_ready = 1'b0;
        tick(); tick();

        // Reset state
        check_eq("rst_request",   32'(request),   32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_last",  32'(out_last),  32'd0);
        check_eq("rst_out_id",    32'(out_id),    32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);
        check_eq("rst_grant_err", 32'(grant_err), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd3);
        rst_n = 1'b1;
        tick();

        // Single burst on ch0
        expect_word(1'b0, 8'h11, 1'b0);
        expect_word(1'b0, 8'h22, 1'b0);
        expect_word(1'b0, 8'h33, 1'b1);
        write_word(0, 8'h11);
        check_eq("t1_req_early", 32'(request[0]), 32'd0);
        write_word(0, 8'h22);
        check_eq("t1_req_rise", 32'(request[0]), 32'd1);
        write_word(0, 8'h33);
        grant = 2'b01; out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check_eq("t1_rel", 32'(request[0]), 32'd0);
        grant = 2'b00;
        tick();
        check_eq("t1_idle", 32'(request), 32'd0);
        check_eq("t1_drain", 32'(exp_q.size()), 32'd0);

        // Burst limit on ch1
        expect_word(1'b1, 8'hA0, 1'b0);
        expect_word(1'b1, 8'hA1, 1'b0);
        expect_word(1'b1, 8'hA2, 1'b1);
        expect_word(1'b1, 8'hA3, 1'b1);
        for (int k = 0; k < 4; k++) write_word(1, 8'(8'hA0 + k));
        grant = 2'b10; out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check_eq("t2_rel", 32'(request[1]), 32'd0);
        tick();
        check_eq("t2_rereq", 32'(request[1]), 32'd1);
        wait_drained("t2_drain", 8);
        grant = 2'b00;
        tick(); tick(); tick();
        check_eq("t2_settle", 32'(request), 32'd0);

        // Backpressure on ch0
        expect_word(1'b0, 8'h31, 1'b0);
        expect_word(1'b0, 8'h32, 1'b1);
        write_word(0, 8'h31);
        write_word(0, 8'h32);
        grant = 2'b01; out_ready = 1'b0;
        tick();
        base = accepted;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t3_stall_valid", 32'(out_valid), 32'd1);
        check_eq("t3_stall_data",  32'(out_data),  32'h32);
        tick();
        check_eq("t3_stall_data2", 32'(out_data),  32'h32);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        grant = 2'b00;
        tick(); tick();
        check_eq("t3_accepted", 32'(accepted - base), 32'd2);

        // Grant pulled mid-burst on ch0
        expect_word(1'b0, 8'h41, 1'b0);
        expect_word(1'b0, 8'h42, 1'b0);
        expect_word(1'b0, 8'h43, 1'b1);
        write_word(0, 8'h41);
        write_word(0, 8'h42);
        write_word(0, 8'h43);
        grant = 2'b01; out_ready = 1'b1;
        tick(); tick();
        grant = 2'b00;
        #1;
        check_eq("t4_drop_valid", 32'(out_valid), 32'd0);
        tick();
        check_eq("t4_req_held", 32'(request[0]), 32'd1);
        check_eq("t4_one_word", 32'(exp_q.size()), 32'd2);
        grant = 2'b01;
        wait_drained("t4_drain", 8);
        grant = 2'b00;
        tick(); tick(); tick();

        // Full FIFO and simultaneous push/pop on ch1
        expect_word(1'b1, 8'h51, 1'b0);
        expect_word(1'b1, 8'h52, 1'b0);
        expect_word(1'b1, 8'h53, 1'b1);
        expect_word(1'b1, 8'h54, 1'b0);
        expect_word(1'b1, 8'h55, 1'b1);
        for (int k = 0; k < 4; k++) write_word(1, 8'(8'h51 + k));
        check_eq("t5_full", 32'(in_ready), 32'd1);
        grant = 2'b10; out_ready = 1'b1;
        tick();
        write_word(1, 8'h55);
        check_eq("t5_still_full", 32'(in_ready[1]), 32'd0);
        wait_drained("t5_drain", 12);
        grant = 2'b00;
        tick(); tick(); tick();

        // Illegal grant
        write_word(0, 8'h61);
        tick();
        grant = 2'b01; out_ready = 1'b0;
        tick();
        check_eq("t5_pre_valid", 32'(out_valid), 32'd1);
        grant = 2'b11;
        #1;
        check_eq("t5_illegal_valid", 32'(out_valid), 32'd0);
        tick();
        check_eq("t5_err_set", 32'(grant_err), 32'd1);
        grant = 2'b00;
        tick();
        check_eq("t5_err_sticky", 32'(grant_err), 32'd1);

        // Reset during a transfer
        write_word(0, 8'h71);
        grant = 2'b01; out_ready = 1'b0;
        tick();
        check_eq("t6_xfer_valid", 32'(out_valid), 32'd1);
        check_eq("t6_req",        32'(request),   32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_req",   32'(request),   32'd0);
        check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
        grant = 2'b00;
        tick(); tick();
        rst_n = 1'b1;
        check_eq("t6_in_ready", 32'(in_ready),  32'd3);
        check_eq("t6_err_clr",  32'(grant_err), 32'd0);
        tick(); tick(); tick();
        check_eq("t6_empty",    32'(request),   32'd0);
        check_eq("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
